// File: rtl/fib_pkg.sv
// Shared types and constants for the iterative Fibonacci generator.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fib_state_t;

    // Largest index whose Fibonacci number fits in 32 unsigned bits.
    localparam int FIB_MAX_N32 = 47;

    localparam logic [63:0] FIB_SAT = '1;

endpackage

// File: rtl/fibonacci.sv
// Iterative Fibonacci generator: one addition per clock, saturating result
// with an overflow flag for indices beyond MAX_N.
module fibonacci
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAX_N = FIB_MAX_N32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] fib,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    fib_state_t       state;
    fib_state_t       state_nxt;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] a;
    // One spare bit: the final iteration for n = MAX_N leaves fib(MAX_N+1) here.
    logic [WIDTH:0]   b;

    logic accept;
    logic too_big;
    logic last;

    assign busy    = (state == RUN);
    assign accept  = (state == IDLE) && start;
    assign too_big = (n_q > WIDTH'(MAX_N));
    assign last    = (cnt == n_q);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (too_big || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            cnt      <= '0;
            a        <= '0;
            b        <= (WIDTH+1)'(1);
            fib      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                n_q <= n;
                a   <= '0;
                b   <= (WIDTH+1)'(1);
                cnt <= '0;
            end else if (state == RUN) begin
                if (too_big) begin
                    fib      <= WIDTH'(FIB_SAT);
                    overflow <= 1'b1;
                    done     <= 1'b1;
                end else if (last) begin
                    fib      <= a;
                    overflow <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    // a never exceeds fib(MAX_N) when it is loaded, so the
                    // truncation drops only a zero bit.
                    a   <= b[WIDTH-1:0];
                    b   <= b + {1'b0, a};
                    cnt <= cnt + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fibonacci.sv
// Scoreboard bench for the iterative Fibonacci generator.
module tb_fibonacci;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] n;
    logic [31:0] fib;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] fib;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fibonacci #(.WIDTH(32), .MAX_N(47)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n        (n),
        .fib      (fib),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // Reference: 64-bit iteration, saturation beyond index 47.
    function automatic exp_t model(input logic [31:0] idx);
        exp_t e;
        longint unsigned x = 0;
        longint unsigned y = 1;
        longint unsigned t;
        e.idx = idx;
        if (idx > 32'd47) begin
            e.fib = 32'hFFFF_FFFF;
            e.ovf = 1'b1;
            e.lat = 1;
        end else begin
            for (int i = 0; i < int'(idx); i++) begin
                t = x + y;
                x = y;
                y = t;
            end
            e.fib = x[31:0];
            e.ovf = 1'b0;
            e.lat = int'(idx) + 1;
        end
        return e;
    endfunction

    // Drive one request; returns #1 after the sampling edge.
    task automatic send(input logic [31:0] idx);
        @(negedge clk);
        start = 1'b1;
        n     = idx;
        sb.push_back(model(idx));
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = $urandom;
    endtask

    // Count edges until done; optionally pulse start (with inj_n) after edge inj_at.
    task automatic wait_done(input int inj_at, input logic [31:0] inj_n,
                             output logic [31:0] f, output logic o,
                             output int lat, output bit timeout);
        lat     = 0;
        timeout = 1'b1;
        f       = '0;
        o       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == inj_at) begin
                start = 1'b1;
                n     = inj_n;
            end else if (lat == inj_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                timeout = 1'b0;
                f       = fib;
                o       = overflow;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fib, busy, done, overflow} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: fib=%h busy=%b done=%b ovf=%b, want all zero",
                     fib, busy, done, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_values();
        logic [31:0] idx_tab [9] = '{32'd0, 32'd1, 32'd2, 32'd10, 32'd15,
                                    32'd20, 32'd47, 32'd48, 32'hFFFF_FFFF};
        logic [31:0] f;
        logic        o;
        int          lat;
        bit          to;
        exp_t        e;
        foreach (idx_tab[k]) begin
            send(idx_tab[k]);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL busy_after_accept n=%0d: busy=%b done=%b, want 1/0",
                         idx_tab[k], busy, done);
            end
            wait_done(-10, '0, f, o, lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                failures++;
                $display("FAIL done_timeout n=%0d: no done within budget", e.idx);
            end else if (f !== e.fib || o !== e.ovf || lat != e.lat || busy !== 1'b0) begin
                failures++;
                $display("FAIL result n=%0d: fib=%0d ovf=%b lat=%0d busy=%b, want fib=%0d ovf=%b lat=%0d busy=0",
                         e.idx, f, o, lat, busy, e.fib, e.ovf, e.lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL done_single_pulse n=%0d: done=%b busy=%b, want 0/0",
                         e.idx, done, busy);
            end
        end
    endtask

    task automatic test_hold();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (fib !== 32'hFFFF_FFFF || overflow !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL hold: fib=%h ovf=%b done=%b, want ffffffff/1/0", fib, overflow, done);
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] f;
        logic        o;
        int          lat;
        bit          to;
        int          extra;
        exp_t        e;
        send(32'd20);
        wait_done(3, 32'd5, f, o, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || f !== e.fib || o !== e.ovf || lat != e.lat) begin
            failures++;
            $display("FAIL ignore_busy: timeout=%b fib=%0d ovf=%b lat=%0d, want fib=%0d ovf=%b lat=%0d",
                     to, f, o, lat, e.fib, e.ovf, e.lat);
        end
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_busy_extra: %0d cycles with done/busy after completion, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] f;
        logic        o;
        int          lat;
        bit          to;
        int          seen;
        exp_t        e;
        send(32'd20);
        repeat (7) @(posedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_abort: busy=%b, want 1", busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fib, busy, done, overflow} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset: fib=%h busy=%b done=%b ovf=%b, want all zero",
                     fib, busy, done, overflow);
        end
        void'(sb.pop_front());
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d cycles with done/busy after abort, want 0", seen);
        end
        send(32'd10);
        wait_done(-10, '0, f, o, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || f !== e.fib || o !== e.ovf || lat != e.lat) begin
            failures++;
            $display("FAIL after_reset n=10: timeout=%b fib=%0d ovf=%b lat=%0d, want fib=%0d lat=%0d",
                     to, f, o, lat, e.fib, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        logic        o;
        int          lat;
        bit          to;
        exp_t        e;
        send(32'd10);
        wait_done(-10, '0, f, o, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || f !== e.fib || lat != e.lat) begin
            failures++;
            $display("FAIL b2b_first n=10: timeout=%b fib=%0d lat=%0d, want fib=%0d lat=%0d",
                     to, f, lat, e.fib, e.lat);
        end
        // Still inside the done cycle: request the next index.
        start = 1'b1;
        n     = 32'd15;
        sb.push_back(model(32'd15));
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(-10, '0, f, o, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || f !== e.fib || o !== e.ovf || lat != e.lat) begin
            failures++;
            $display("FAIL b2b_second n=15: timeout=%b fib=%0d ovf=%b lat=%0d, want fib=%0d ovf=%b lat=%0d",
                     to, f, o, lat, e.fib, e.ovf, e.lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_values();
        test_hold();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
